// File: rtl/life_frame_scanner.sv
// Snapshots the cell array's state vector on start and streams it
// out one cell per valid/ready handshake, row-major, with markers.
//
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   states            : live/dead vector, bit row*WIDTH+col
//   start             : snapshot and scan one frame (taken in IDLE only)
//   busy              : frame scan in progress
//   out_valid/ready   : cell stream handshake
//   out_cell          : current cell, 1 = live
//   out_sof/eol/eof   : first cell / last col of row / last cell
//   population        : live count of the last completed frame
//   pop_valid         : one-cycle pulse when population updates
module life_frame_scanner #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20,
    localparam int N     = WIDTH * HEIGHT,
    localparam int PW    = $clog2(N + 1),
    localparam int CW    = $clog2(WIDTH),
    localparam int RW    = $clog2(HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  states,
    input  logic          start,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_cell,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic [PW-1:0] population,
    output logic          pop_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  shadow_q, shadow_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] pop_q, pop_d;
    logic          pop_valid_q, pop_valid_d;

    logic scan;
    logic xfer;
    logic eol;
    logic eof;

    assign scan = (state_q == SCAN);
    assign xfer = scan && out_ready;
    assign eol  = (col_q == CW'(WIDTH - 1));
    assign eof  = eol && (row_q == RW'(HEIGHT - 1));

    assign busy       = scan;
    assign out_valid  = scan;
    // The shadow shifts right on every transfer, so the current
    // cell is always bit 0 and no row*WIDTH+col index is needed.
    assign out_cell   = scan && shadow_q[0];
    assign out_sof    = scan && (row_q == '0) && (col_q == '0);
    assign out_eol    = scan && eol;
    assign out_eof    = scan && eof;
    assign population = pop_q;
    assign pop_valid  = pop_valid_q;

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        row_d       = row_q;
        col_d       = col_q;
        acc_d       = acc_q;
        pop_d       = pop_q;
        pop_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = states;
                    row_d    = '0;
                    col_d    = '0;
                    acc_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (xfer) begin
                    shadow_d = shadow_q >> 1;
                    acc_d    = acc_q + PW'(shadow_q[0]);
                    if (eof) begin
                        pop_d       = acc_q + PW'(shadow_q[0]);
                        pop_valid_d = 1'b1;
                        row_d       = '0;
                        col_d       = '0;
                        state_d     = IDLE;
                    end else if (eol) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            pop_q       <= '0;
            pop_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            row_q       <= row_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            pop_q       <= pop_d;
            pop_valid_q <= pop_valid_d;
        end
    end

endmodule
